// File: rtl/wram_dram_ctrl.sv
// Work-RAM DRAM timing controller: decodes 68k $E00000-$FFFFFF accesses into
// RAS/CAS/WE/OE sequences and interleaves periodic CAS-before-RAS refresh.
module wram_dram_ctrl #(
  parameter int unsigned T_RCD      = 2,
  parameter int unsigned T_RP       = 3,
  parameter int unsigned T_REF_RAS  = 4,
  parameter int unsigned REF_PERIOD = 128
) (
  input  logic       MCLK,
  input  logic       n_SRES,
  input  logic       n_AS,
  input  logic       n_UDS,
  input  logic       n_LDS,
  input  logic       RW,
  input  logic [2:0] VA,
  output logic       n_RAS0,
  output logic       n_CAS0,
  output logic       n_WE_U,
  output logic       n_WE_L,
  output logic       n_OE,
  output logic       REF_ACT,
  output logic       REF_OVR
);

  localparam int unsigned REF_W  = $clog2(REF_PERIOD);
  localparam int unsigned T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned T_MAX  = (T_MAX0 > T_REF_RAS) ? T_MAX0 : T_REF_RAS;
  localparam int unsigned TMR_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACT  = 3'd1,
    CAS  = 3'd2,
    PRE  = 3'd3,
    RCAS = 3'd4,
    RRAS = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [TMR_W-1:0]  tmr, tmr_d;
  logic [REF_W-1:0]  ref_cnt, ref_cnt_d;
  logic              ref_pend, ref_pend_d;
  logic              ref_clr_c;
  logic              ref_zero_c;
  logic              sel_c;
  logic              ras_d, cas_d, we_u_d, we_l_d, oe_d, ref_act_d, ref_ovr_d;

  assign sel_c = (VA == 3'b111) && !n_AS;

  // State, phase timer and registered strobes
  always_ff @(posedge MCLK or negedge n_SRES) begin
    if (!n_SRES) begin
      state   <= IDLE;
      tmr     <= '0;
      n_RAS0  <= 1'b1;
      n_CAS0  <= 1'b1;
      n_WE_U  <= 1'b1;
      n_WE_L  <= 1'b1;
      n_OE    <= 1'b1;
      REF_ACT <= 1'b0;
    end else begin
      state   <= state_d;
      tmr     <= tmr_d;
      n_RAS0  <= ras_d;
      n_CAS0  <= cas_d;
      n_WE_U  <= we_u_d;
      n_WE_L  <= we_l_d;
      n_OE    <= oe_d;
      REF_ACT <= ref_act_d;
    end
  end

  // Next state; strobes are decoded from the state being entered
  always_comb begin
    state_d   = state;
    tmr_d     = tmr;
    ref_clr_c = 1'b0;
    ras_d     = 1'b1;
    cas_d     = 1'b1;
    we_u_d    = 1'b1;
    we_l_d    = 1'b1;
    oe_d      = 1'b1;
    ref_act_d = 1'b0;

    unique case (state)
      IDLE: begin
        if (ref_pend) begin
          state_d = RCAS;
        end else if (sel_c) begin
          state_d = ACT;
          tmr_d   = TMR_W'(T_RCD - 1);
        end
      end
      ACT: begin
        if (n_AS) begin
          state_d = PRE;
          tmr_d   = TMR_W'(T_RP - 1);
        end else if (tmr == '0) begin
          state_d = CAS;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      CAS: begin
        if (n_AS) begin
          state_d = PRE;
          tmr_d   = TMR_W'(T_RP - 1);
        end
      end
      PRE: begin
        if (tmr == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      RCAS: begin
        state_d = RRAS;
        tmr_d   = TMR_W'(T_REF_RAS - 1);
      end
      RRAS: begin
        if (tmr == '0) begin
          state_d   = PRE;
          tmr_d     = TMR_W'(T_RP - 1);
          ref_clr_c = 1'b1;
        end else begin
          tmr_d = tmr - TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    unique case (state_d)
      ACT: begin
        ras_d = 1'b0;
      end
      CAS: begin
        ras_d = 1'b0;
        cas_d = 1'b0;
        if (RW) begin
          oe_d = 1'b0;
        end else begin
          we_u_d = n_UDS;
          we_l_d = n_LDS;
        end
      end
      RCAS: begin
        cas_d     = 1'b0;
        ref_act_d = 1'b1;
      end
      RRAS: begin
        ras_d     = 1'b0;
        cas_d     = 1'b0;
        ref_act_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Refresh request timer; a request landing on an unserviced one is lost
  always_comb begin
    ref_zero_c = (ref_cnt == '0);
    ref_cnt_d  = ref_zero_c ? REF_W'(REF_PERIOD - 1) : (ref_cnt - REF_W'(1));
    ref_ovr_d  = ref_zero_c && ref_pend && !ref_clr_c;
    if (ref_zero_c) begin
      ref_pend_d = 1'b1;
    end else if (ref_clr_c) begin
      ref_pend_d = 1'b0;
    end else begin
      ref_pend_d = ref_pend;
    end
  end

  always_ff @(posedge MCLK or negedge n_SRES) begin
    if (!n_SRES) begin
      ref_cnt  <= REF_W'(REF_PERIOD - 1);
      ref_pend <= 1'b0;
      REF_OVR  <= 1'b0;
    end else begin
      ref_cnt  <= ref_cnt_d;
      ref_pend <= ref_pend_d;
      REF_OVR  <= ref_ovr_d;
    end
  end

endmodule
